// File: rtl/synapse_fetch_scheduler_if.sv
// Bundles the spike/boot request inputs, the BRAM port-B read side and the
// tagged read-data strobes of the synapse fetch scheduler.
interface synapse_fetch_scheduler_if #(
  parameter int N_NEURONS = 30,
  parameter int ADDR_W    = 10
);
  logic                 boot_req;
  logic [N_NEURONS-1:0] spike_in;
  logic                 bram_en;
  logic [ADDR_W-1:0]    bram_addr;
  logic                 rd_valid;
  logic                 rd_first;
  logic                 rd_last;
  logic [4:0]           rd_tag;
  logic                 rd_boot;
  logic                 busy;
  logic [N_NEURONS-1:0] pending;
  logic                 spike_merged;

  modport master (
    output boot_req, spike_in,
    input  bram_en, bram_addr, rd_valid, rd_first, rd_last, rd_tag, rd_boot,
           busy, pending, spike_merged
  );

  modport slave (
    input  boot_req, spike_in,
    output bram_en, bram_addr, rd_valid, rd_first, rd_last, rd_tag, rd_boot,
           busy, pending, spike_merged
  );
endinterface

// File: rtl/synapse_fetch_scheduler.sv
// Shares the weight/bias BRAM read port between 30 spike requesters and the boot bias fetch.
// Define SFS_ROUND_ROBIN_EN for rotating priority; otherwise lowest pending index wins.
//
// state | meaning
// IDLE  | no burst in flight; bram_en low; grant decided from boot_pend / pending
// ISSUE | driving burst beat beat_q on bram_addr with bram_en high
module synapse_fetch_scheduler #(
  parameter int N_NEURONS = 30,
  parameter int ADDR_W    = 10,
  parameter int BURST     = 2,
  parameter int STRIDE    = 2,
  parameter int BIAS_BASE = 60,
  parameter int BIAS_LEN  = 2,
  parameter int RD_LAT    = 1
) (
  input logic                  clk,
  input logic                  rst,
  synapse_fetch_scheduler_if.slave bus
);

  localparam int RET_W = RD_LAT * 9;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t               state_q, state_d;
  logic [N_NEURONS-1:0] pending_q, pending_d, grant_vec;
  logic                 boot_pend_q, boot_pend_d, grant_boot;
  logic [ADDR_W-1:0]    base_q, base_d, addr_q, addr_d;
  logic [1:0]           beat_q, beat_d, last_beat_q, last_beat_d;
  logic                 en_q, en_d, first_q, first_d, last_q, last_d;
  logic                 boot_q, boot_d, merged_q, merged_d;
  logic [4:0]           tag_q, tag_d;
  logic                 arb_found;
  logic [4:0]           arb_idx, cand;
  logic [8:0]           ret_in;
  logic [RD_LAT-1:0][8:0] ret_q;
`ifdef SFS_ROUND_ROBIN_EN
  logic [4:0]           last_grant_q, last_grant_d;
`endif

  // Scan the pending set once, starting one past the last winner when rotating.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
`ifdef SFS_ROUND_ROBIN_EN
      cand = 5'((int'(last_grant_q) + 1 + k) % N_NEURONS);
`else
      cand = 5'(k);
`endif
      if (!arb_found && pending_q[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    beat_d      = beat_q;
    last_beat_d = last_beat_q;
    en_d        = 1'b0;
    addr_d      = '0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    tag_d       = '0;
    boot_d      = 1'b0;
    grant_vec   = '0;
    grant_boot  = 1'b0;
`ifdef SFS_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (boot_pend_q) begin
          grant_boot  = 1'b1;
          base_d      = ADDR_W'(BIAS_BASE);
          last_beat_d = 2'(BIAS_LEN - 1);
          beat_d      = '0;
          en_d        = 1'b1;
          addr_d      = ADDR_W'(BIAS_BASE);
          first_d     = 1'b1;
          last_d      = (BIAS_LEN == 1);
          boot_d      = 1'b1;
          state_d     = ISSUE;
        end else if (arb_found) begin
          grant_vec[arb_idx] = 1'b1;
          base_d      = ADDR_W'(arb_idx) * ADDR_W'(STRIDE);
          last_beat_d = 2'(BURST - 1);
          beat_d      = '0;
          en_d        = 1'b1;
          addr_d      = ADDR_W'(arb_idx) * ADDR_W'(STRIDE);
          first_d     = 1'b1;
          last_d      = (BURST == 1);
          tag_d       = arb_idx;
          state_d     = ISSUE;
`ifdef SFS_ROUND_ROBIN_EN
          last_grant_d = arb_idx;
`endif
        end
      end
      ISSUE: begin
        // Leaving on the last beat guarantees one dead cycle before the next grant.
        if (beat_q == last_beat_q) begin
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 2'd1;
          en_d   = 1'b1;
          addr_d = base_q + ADDR_W'(beat_d);
          last_d = (beat_d == last_beat_q);
          tag_d  = tag_q;
          boot_d = boot_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A spike landing on the bit being granted re-arms it.
    pending_d   = (pending_q & ~grant_vec) | bus.spike_in;
    merged_d    = |(bus.spike_in & pending_q & ~grant_vec);
    boot_pend_d = (boot_pend_q & ~grant_boot) | bus.boot_req;
  end

  assign ret_in = {en_q, first_q, last_q, tag_q, boot_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      boot_pend_q <= 1'b0;
      base_q      <= '0;
      addr_q      <= '0;
      beat_q      <= '0;
      last_beat_q <= '0;
      en_q        <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      tag_q       <= '0;
      boot_q      <= 1'b0;
      merged_q    <= 1'b0;
      ret_q       <= '0;
`ifdef SFS_ROUND_ROBIN_EN
      last_grant_q <= 5'(N_NEURONS - 1);
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      boot_pend_q <= boot_pend_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      last_beat_q <= last_beat_d;
      en_q        <= en_d;
      first_q     <= first_d;
      last_q      <= last_d;
      tag_q       <= tag_d;
      boot_q      <= boot_d;
      merged_q    <= merged_d;
      ret_q       <= (ret_q << 9) | RET_W'(ret_in);
`ifdef SFS_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.bram_en      = en_q;
  assign bus.bram_addr    = addr_q;
  assign bus.rd_valid     = ret_q[RD_LAT-1][8];
  assign bus.rd_first     = ret_q[RD_LAT-1][7];
  assign bus.rd_last      = ret_q[RD_LAT-1][6];
  assign bus.rd_tag       = ret_q[RD_LAT-1][5:1];
  assign bus.rd_boot      = ret_q[RD_LAT-1][0];
  assign bus.busy         = (state_q != IDLE);
  assign bus.pending      = pending_q;
  assign bus.spike_merged = merged_q;

endmodule

// File: tb/tb_synapse_fetch_scheduler.sv
// Checks synapse_fetch_scheduler against a transaction-level model (pending set,
// burst word queue, read-latency delay line) plus directed literal scenarios.
module tb_synapse_fetch_scheduler;
  localparam int N         = 30;
  localparam int AW        = 10;
  localparam int BURST     = 2;
  localparam int STRIDE    = 2;
  localparam int BIAS_BASE = 60;
  localparam int BIAS_LEN  = 2;
  localparam int RD_LAT    = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  synapse_fetch_scheduler_if #(.N_NEURONS(N), .ADDR_W(AW)) bus();

  synapse_fetch_scheduler #(
    .N_NEURONS(N), .ADDR_W(AW), .BURST(BURST), .STRIDE(STRIDE),
    .BIAS_BASE(BIAS_BASE), .BIAS_LEN(BIAS_LEN), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic          first;
    logic          last;
    logic [4:0]    tag;
    logic          boot;
  } word_t;

  // reference model state
  logic [N-1:0] m_pending;
  logic         m_boot_pend;
  logic         m_merged;
  word_t        m_cur;
  word_t        m_pipe[RD_LAT];
  word_t        m_q[$];
`ifdef SFS_ROUND_ROBIN_EN
  int           m_last_grant;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit check_en = 1'b0;

  int    iss_addr[$];
  int    iss_cyc[$];
  word_t rd_log[$];
  int    rd_cyc[$];
  int    merged_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick();
`ifdef SFS_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last_grant + k) % N;
      if (m_pending[i]) return i;
    end
`else
    for (int k = 0; k < N; k++)
      if (m_pending[k]) return k;
`endif
    return -1;
  endfunction

  task automatic model_update();
    word_t        w;
    logic [N-1:0] g;
    logic         gb;
    int           idx;
    if (rst) begin
      m_pending   = '0;
      m_boot_pend = 1'b0;
      m_merged    = 1'b0;
      m_cur       = '0;
      for (int i = 0; i < RD_LAT; i++) m_pipe[i] = '0;
      m_q.delete();
`ifdef SFS_ROUND_ROBIN_EN
      m_last_grant = N - 1;
`endif
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = m_cur;
      g  = '0;
      gb = 1'b0;
      // the port can only be granted from a cycle with no read issued
      if (!m_cur.en) begin
        if (m_boot_pend) begin
          gb = 1'b1;
          for (int b = 0; b < BIAS_LEN; b++) begin
            w       = '0;
            w.en    = 1'b1;
            w.addr  = AW'(BIAS_BASE + b);
            w.first = (b == 0);
            w.last  = (b == BIAS_LEN - 1);
            w.boot  = 1'b1;
            m_q.push_back(w);
          end
        end else if (m_pending != 0) begin
          idx    = pick();
          g[idx] = 1'b1;
`ifdef SFS_ROUND_ROBIN_EN
          m_last_grant = idx;
`endif
          for (int b = 0; b < BURST; b++) begin
            w       = '0;
            w.en    = 1'b1;
            w.addr  = AW'((idx * STRIDE + b) % (1 << AW));
            w.first = (b == 0);
            w.last  = (b == BURST - 1);
            w.tag   = 5'(idx);
            m_q.push_back(w);
          end
        end
      end
      m_merged    = |(bus.spike_in & m_pending & ~g);
      m_pending   = (m_pending & ~g) | bus.spike_in;
      m_boot_pend = (m_boot_pend & ~gb) | bus.boot_req;
      m_cur       = (m_q.size() > 0) ? m_q.pop_front() : '0;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_addr.delete();
    iss_cyc.delete();
    rd_log.delete();
    rd_cyc.delete();
    merged_cnt = 0;
  endtask

  function automatic int ia(input int i);
    return (i < iss_addr.size()) ? iss_addr[i] : -1;
  endfunction

  function automatic int ic(input int i);
    return (i < iss_cyc.size()) ? iss_cyc[i] : -1000;
  endfunction

  function automatic word_t rl(input int i);
    return (i < rd_log.size()) ? rd_log[i] : '0;
  endfunction

  task automatic expect_issues(input string name, input int n, input int exp[6]);
    chk({name, "_count"}, iss_addr.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_addr%0d", name, i), ia(i), exp[i]);
  endtask

  // compare process: DUT against the model every cycle, and log DUT activity
  initial begin
    word_t r;
    forever begin
      @(negedge clk);
      if (check_en) begin
        r = m_pipe[RD_LAT-1];
        chk("bram_en",      bus.bram_en,      m_cur.en);
        chk("bram_addr",    bus.bram_addr,    m_cur.addr);
        chk("rd_valid",     bus.rd_valid,     r.en);
        chk("rd_first",     bus.rd_first,     r.first);
        chk("rd_last",      bus.rd_last,      r.last);
        chk("rd_tag",       bus.rd_tag,       r.tag);
        chk("rd_boot",      bus.rd_boot,      r.boot);
        chk("busy",         bus.busy,         m_cur.en);
        chk("pending",      bus.pending,      m_pending);
        chk("spike_merged", bus.spike_merged, m_merged);
      end
      if (bus.bram_en === 1'b1) begin
        iss_addr.push_back(int'(bus.bram_addr));
        iss_cyc.push_back(cyc);
      end
      if (bus.rd_valid === 1'b1) begin
        rd_log.push_back({1'b1, AW'(0), bus.rd_first, bus.rd_last, bus.rd_tag, bus.rd_boot});
        rd_cyc.push_back(cyc);
      end
      if (bus.spike_merged === 1'b1) merged_cnt++;
    end
  end

  initial begin
    int    c0;
    int    n12;
    word_t w;
    rst          = 1'b1;
    bus.spike_in = '0;
    bus.boot_req = 1'b0;
    clear_logs();
    repeat (2) tick();
    check_en = 1'b1;
    tick();
    chk("reset_bram_en",  bus.bram_en,  0);
    chk("reset_rd_valid", bus.rd_valid, 0);
    chk("reset_pending",  bus.pending,  0);
    chk("reset_busy",     bus.busy,     0);
    rst = 1'b0;
    tick();

    // boot fetch
    clear_logs();
    bus.boot_req = 1'b1;
    tick();
    bus.boot_req = 1'b0;
    repeat (6) tick();
    expect_issues("boot", 2, '{60, 61, 0, 0, 0, 0});
    chk("boot_consecutive", ic(1) - ic(0), 1);
    chk("boot_rd_count", rd_log.size(), 2);
    w = rl(0);
    chk("boot_rd0_flags", {w.first, w.last, w.boot}, 3'b101);
    w = rl(1);
    chk("boot_rd1_flags", {w.first, w.last, w.boot}, 3'b011);
    chk("boot_rd_latency", (rd_cyc.size() > 0 ? rd_cyc[0] : -1000) - ic(0), 1);

    // single spike on neuron 5
    clear_logs();
    c0 = cyc;
    bus.spike_in[5] = 1'b1;
    tick();
    bus.spike_in = '0;
    chk("spike5_pending_set", bus.pending[5], 1);
    chk("spike5_not_yet", bus.bram_en, 0);
    tick();
    chk("spike5_addr_first", bus.bram_addr, 10);
    chk("spike5_pending_clr", bus.pending[5], 0);
    repeat (4) tick();
    expect_issues("spike5", 2, '{10, 11, 0, 0, 0, 0});
    chk("spike5_latency", ic(0) - c0, 2);
    w = rl(0);
    chk("spike5_rd0_tag", w.tag, 5);
    w = rl(1);
    chk("spike5_rd1_tag", w.tag, 5);

    // arbitration order after serving neuron 3
    bus.spike_in[3] = 1'b1;
    tick();
    bus.spike_in = '0;
    repeat (6) tick();
    clear_logs();
    bus.spike_in[2] = 1'b1;
    bus.spike_in[4] = 1'b1;
    tick();
    bus.spike_in = '0;
    repeat (10) tick();
`ifdef SFS_ROUND_ROBIN_EN
    expect_issues("arb", 4, '{8, 9, 4, 5, 0, 0});
`else
    expect_issues("arb", 4, '{4, 5, 8, 9, 0, 0});
`endif
    chk("arb_gap", ic(2) - ic(1), 2);

    // boot request arriving while neuron 7 bursts with 8 waiting
    clear_logs();
    bus.spike_in[7] = 1'b1;
    tick();
    bus.spike_in    = '0;
    bus.spike_in[8] = 1'b1;
    tick();
    bus.spike_in = '0;
    bus.boot_req = 1'b1;
    tick();
    bus.boot_req = 1'b0;
    repeat (12) tick();
    expect_issues("boot_mid", 6, '{14, 15, 60, 61, 16, 17});

    // double spike on neuron 9 while it waits behind a boot burst
    clear_logs();
    bus.boot_req = 1'b1;
    tick();
    bus.boot_req    = 1'b0;
    bus.spike_in[9] = 1'b1;
    tick();
    tick();
    bus.spike_in = '0;
    repeat (8) tick();
    expect_issues("merge", 4, '{60, 61, 18, 19, 0, 0});
    chk("merge_pulses", merged_cnt, 1);

    // reset on the second beat of neuron 12
    clear_logs();
    bus.spike_in[12] = 1'b1;
    tick();
    bus.spike_in     = '0;
    bus.spike_in[20] = 1'b1;
    tick();
    bus.spike_in = '0;
    tick();
    chk("rst_pre_addr", bus.bram_addr, 25);
    rst = 1'b1;
    tick();
    chk("rst_bram_en",  bus.bram_en,  0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_pending",  bus.pending,  0);
    chk("rst_busy",     bus.busy,     0);
    rst = 1'b0;
    repeat (6) tick();
    n12 = 0;
    foreach (rd_log[i]) if (rd_log[i].tag == 5'd12) n12++;
    chk("rst_rd_tag12_words", n12, 1);
    chk("rst_issue_count", iss_addr.size(), 2);

    // randomized traffic
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < N; i++) bus.spike_in[i] = ($urandom_range(23) == 0);
      bus.boot_req = ($urandom_range(63) == 0);
      rst          = ($urandom_range(499) == 0);
      tick();
    end
    bus.spike_in = '0;
    bus.boot_req = 1'b0;
    rst          = 1'b0;
    repeat (200) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
